// File: rtl/band_sequencer_pkg.sv
// Shared types and reset-table constants for the band sequencer.
`timescale 1ns/1ps
package band_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SATURATE = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  localparam int RST_LIMIT0 = 2;
  localparam int RST_LIMIT1 = 3;
  localparam int RST_CODE0  = 10;
  localparam int RST_CODE1  = 20;
  localparam int DEF_CODE   = 30;

  function automatic int rst_limit(input int idx);
    return (idx == 0) ? RST_LIMIT0 : (idx == 1) ? RST_LIMIT1 : 0;
  endfunction

  function automatic int rst_code(input int idx);
    return (idx == 0) ? RST_CODE0 : (idx == 1) ? RST_CODE1 : 0;
  endfunction

endpackage

// File: rtl/band_sequencer_if.sv
// Control, table-config and status bundle of the band sequencer.
`timescale 1ns/1ps
interface band_sequencer_if
  import band_sequencer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_BANDS = 4,
  parameter int CODE_W    = 8
);
  localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int BAND_W = $clog2(NUM_BANDS + 1);

  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  mode_e             mode;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [WIDTH-1:0]  cfg_limit;
  logic [CODE_W-1:0] cfg_code;
  logic [WIDTH-1:0]  count_out;
  logic [CODE_W-1:0] code_out;
  logic [BAND_W-1:0] band_out;
  logic              band_change;
  logic              at_limit;

  modport master (
    output en, load, load_val, mode, cfg_we, cfg_idx, cfg_limit, cfg_code,
    input  count_out, code_out, band_out, band_change, at_limit
  );

  modport slave (
    input  en, load, load_val, mode, cfg_we, cfg_idx, cfg_limit, cfg_code,
    output count_out, code_out, band_out, band_change, at_limit
  );
endinterface

// File: rtl/band_classifier.sv
// Combinational priority scan: lowest-index entry with count <= limit wins.
`timescale 1ns/1ps
module band_classifier #(
  parameter int WIDTH        = 8,
  parameter int NUM_BANDS    = 4,
  parameter int CODE_W       = 8,
  parameter int DEFAULT_CODE = 30,
  parameter int BAND_W       = $clog2(NUM_BANDS + 1)
) (
  input  logic [WIDTH-1:0]                  count,
  input  logic [NUM_BANDS-1:0][WIDTH-1:0]  limits,
  input  logic [NUM_BANDS-1:0][CODE_W-1:0] codes,
  output logic [CODE_W-1:0]                 code,
  output logic [BAND_W-1:0]                 band
);

  // Scan high-to-low so the lowest matching index is written last.
  always_comb begin
    code = CODE_W'(DEFAULT_CODE);
    band = BAND_W'(NUM_BANDS);
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (count <= limits[i]) begin
        code = codes[i];
        band = BAND_W'(i);
      end
    end
  end

endmodule

// File: rtl/band_sequencer.sv
// Multi-mode step counter with a runtime-writable band classification table.
`timescale 1ns/1ps
module band_sequencer
  import band_sequencer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_BANDS    = 4,
  parameter int CODE_W       = 8,
  parameter int DEFAULT_CODE = DEF_CODE
) (
  input  logic       clock,
  input  logic       rst_n,
  band_sequencer_if.slave bus
);

  localparam int BAND_W = $clog2(NUM_BANDS + 1);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]                  count_q, count_d;
  logic                              dir_q, dir_d;
  logic [NUM_BANDS-1:0][WIDTH-1:0]  limit_q, limit_d;
  logic [NUM_BANDS-1:0][CODE_W-1:0] code_q, code_d;
  logic [BAND_W-1:0]                 band_cur, band_nxt;
  logic [CODE_W-1:0]                 code_cur, code_nxt_unused;
  logic                              band_change_q;

  // Post-write table: feeds both the registers and the next-count classifier.
  always_comb begin
    limit_d = limit_q;
    code_d  = code_q;
    if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_BANDS)) begin
      limit_d[bus.cfg_idx] = bus.cfg_limit;
      code_d[bus.cfg_idx]  = bus.cfg_code;
    end
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en) begin
      unique case (bus.mode)
        MODE_WRAP:     count_d = count_q + ONE;
        MODE_SATURATE: if (count_q != MAX) count_d = count_q + ONE;
        MODE_PINGPONG: begin
          // Each end value shows once; direction flips on the step away from it.
          if (!dir_q) begin
            if (count_q == MAX) begin
              count_d = count_q - ONE;
              dir_d   = 1'b1;
            end else begin
              count_d = count_q + ONE;
            end
          end else begin
            if (count_q == '0) begin
              count_d = ONE;
              dir_d   = 1'b0;
            end else begin
              count_d = count_q - ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  band_classifier #(
    .WIDTH(WIDTH), .NUM_BANDS(NUM_BANDS), .CODE_W(CODE_W),
    .DEFAULT_CODE(DEFAULT_CODE), .BAND_W(BAND_W)
  ) u_cls_cur (
    .count(count_q), .limits(limit_q), .codes(code_q),
    .code(code_cur), .band(band_cur)
  );

  band_classifier #(
    .WIDTH(WIDTH), .NUM_BANDS(NUM_BANDS), .CODE_W(CODE_W),
    .DEFAULT_CODE(DEFAULT_CODE), .BAND_W(BAND_W)
  ) u_cls_nxt (
    .count(count_d), .limits(limit_d), .codes(code_d),
    .code(code_nxt_unused), .band(band_nxt)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      count_q       <= '0;
      dir_q         <= 1'b0;
      band_change_q <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        limit_q[i] <= WIDTH'(rst_limit(i));
        code_q[i]  <= CODE_W'(rst_code(i));
      end
    end else begin
      count_q       <= count_d;
      dir_q         <= dir_d;
      limit_q       <= limit_d;
      code_q        <= code_d;
      band_change_q <= (band_nxt != band_cur);
    end
  end

  assign bus.count_out   = count_q;
  assign bus.code_out    = code_cur;
  assign bus.band_out    = band_cur;
  assign bus.band_change = band_change_q;
  assign bus.at_limit    = (count_q == MAX) ||
                           ((bus.mode == MODE_PINGPONG) && dir_q && (count_q == '0));

endmodule
